usb_rx_timer: RTL and testbench

Bit-timing stage of the USB receiver, directly upstream of the receive control unit. Recovers bit timing from the 8x-oversampled line: generates the single-cycle `shift_enable` sample strobe (resynchronised on every data edge), pulses `byte_received` after every 8 data bits, and removes USB stuffed bits with stuff-violation detection. It feeds `shift_enable` to the receive shift register and the control unit, and `byte_received` to the control unit.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_rx_timer_if.sv | 24 ++
 rtl/flex_counter.sv | 55 +++++
 rtl/usb_rx_timer.sv | 103 ++++++++++
 tb/tb_usb_rx_timer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive path.
//   USB_OVERSAMPLE   : clocks per bit period
//   USB_SAMPLE_PHASE : phase count at which a bit is sampled
//   USB_STUFF_LIMIT  : consecutive 1s after which a stuffed 0 is expected
//   USB_SYNC_BYTE    : SYNC pattern (used by the receive control unit)
package usb_rx_pkg;

    localparam int unsigned USB_OVERSAMPLE   = 8;
    localparam int unsigned USB_SAMPLE_PHASE = 3;
    localparam int unsigned USB_STUFF_LIMIT  = 6;
    localparam logic [7:0]  USB_SYNC_BYTE    = 8'b1000_0000;

    // Bits needed to hold values 0..n-1, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_rx_timer_if.sv
// Signal bundle between the bit-timing stage and its neighbours.
//   master : drives line/control inputs (rcving, d_edge, d_orig, eop)
//   slave  : the timer; drives shift_enable, byte_received, stuff_error
interface usb_rx_timer_if;

    logic rcving;
    logic d_edge;
    logic d_orig;
    logic eop;
    logic shift_enable;
    logic byte_received;
    logic stuff_error;

    modport master (
        output rcving, d_edge, d_orig, eop,
        input  shift_enable, byte_received, stuff_error
    );

    modport slave (
        input  rcving, d_edge, d_orig, eop,
        output shift_enable, byte_received, stuff_error
    );

endinterface

// File: rtl/flex_counter.sv
// Parameterised-width up-counter with rollover.
//   clk, n_rst       : clock, asynchronous active-low reset
//   clear_i          : synchronous clear to 0 (highest priority)
//   restart_i        : current cycle counts as 0, so next value is 1
//   count_enable_i   : advance the count
//   rollover_val_i   : last value before wrapping to 0
//   count_o          : current count
//   rollover_flag_o  : registered one-cycle pulse after a wrap
module flex_counter #(
    parameter int unsigned NumCntBits = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear_i,
    input  logic                  restart_i,
    input  logic                  count_enable_i,
    input  logic [NumCntBits-1:0] rollover_val_i,
    output logic [NumCntBits-1:0] count_o,
    output logic                  rollover_flag_o
);

    logic [NumCntBits-1:0] count_q, count_d;
    logic                  flag_q, flag_d;

    always_comb begin
        count_d = count_q;
        flag_d  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (restart_i) begin
            count_d = NumCntBits'(1);
        end else if (count_enable_i) begin
            if (count_q == rollover_val_i) begin
                count_d = '0;
                flag_d  = 1'b1;
            end else begin
                count_d = count_q + NumCntBits'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = flag_q;

endmodule

// File: rtl/usb_rx_timer.sv
// USB receive bit-timing stage: recovers sample points from the oversampled
// line, strobes shift_enable per data bit, pulses byte_received per byte and
// (when USB_RX_BIT_UNSTUFF_EN is defined) drops stuffed bits and flags stuff
// violations. With the macro undefined every sample point shifts and
// stuff_error is tied low.
//   clk, n_rst : clock (OVERSAMPLE x bit rate), asynchronous active-low reset
//   rx_io      : usb_rx_timer_if.slave (rcving, d_edge, d_orig, eop in;
//                shift_enable, byte_received, stuff_error out)
module usb_rx_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = USB_OVERSAMPLE,
    parameter int unsigned SAMPLE_PHASE  = USB_SAMPLE_PHASE,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input logic            clk,
    input logic            n_rst,
    usb_rx_timer_if.slave  rx_io
);

    localparam int unsigned PhaseW = cnt_width(OVERSAMPLE);
    localparam int unsigned BitW   = cnt_width(BITS_PER_BYTE);

    logic [PhaseW-1:0] phase_cnt;
    logic              sample;
    logic              shift_en;

    // d_edge restarts the phase so the edge cycle is phase 0.
    flex_counter #(
        .NumCntBits (PhaseW)
    ) u_phase_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (!rx_io.rcving),
        .restart_i       (rx_io.d_edge),
        .count_enable_i  (1'b1),
        .rollover_val_i  (PhaseW'(OVERSAMPLE - 1)),
        .count_o         (phase_cnt),
        .rollover_flag_o ()
    );

    assign sample = rx_io.rcving && (phase_cnt == PhaseW'(SAMPLE_PHASE));

    flex_counter #(
        .NumCntBits (BitW)
    ) u_bit_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (!rx_io.rcving),
        .restart_i       (1'b0),
        .count_enable_i  (shift_en),
        .rollover_val_i  (BitW'(BITS_PER_BYTE - 1)),
        .count_o         (),
        .rollover_flag_o (rx_io.byte_received)
    );

`ifdef USB_RX_BIT_UNSTUFF_EN
    localparam int unsigned OnesW = cnt_width(USB_STUFF_LIMIT + 1);

    logic [OnesW-1:0] ones_q, ones_d;
    logic             stuff_err_q, stuff_err_d;
    logic             stuff_slot;

    // After USB_STUFF_LIMIT ones the next bit is a stuffed 0 and is dropped.
    assign stuff_slot = sample && (ones_q == OnesW'(USB_STUFF_LIMIT));
    assign shift_en   = sample && !stuff_slot;

    always_comb begin
        ones_d      = ones_q;
        stuff_err_d = 1'b0;
        if (!rx_io.rcving) begin
            ones_d = '0;
        end else if (stuff_slot) begin
            ones_d      = '0;
            stuff_err_d = rx_io.d_orig;
        end else if (sample) begin
            if (rx_io.d_orig && !rx_io.eop) begin
                ones_d = ones_q + OnesW'(1);
            end else begin
                ones_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q      <= '0;
            stuff_err_q <= 1'b0;
        end else begin
            ones_q      <= ones_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    assign rx_io.stuff_error = stuff_err_q;
`else
    assign shift_en          = sample;
    assign rx_io.stuff_error = 1'b0;
`endif

    assign rx_io.shift_enable = shift_en;

endmodule

// File: tb/tb_usb_rx_timer.sv
module tb_usb_rx_timer;

`ifdef USB_RX_BIT_UNSTUFF_EN
    localparam bit Unstuff = 1'b1;
`else
    localparam bit Unstuff = 1'b0;
`endif

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    usb_rx_timer_if ifc ();

    usb_rx_timer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .rx_io (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per bit period (8 clocks); expected values at the sample.
    typedef struct {
        bit start;  // drop rcving for 2 cycles before this bit
        bit d;
        bit eop;
        bit se;     // expected shift_enable at phase 3
        bit br;     // expected byte_received at phase 4
        bit err;    // expected stuff_error at phase 4
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit start, input bit d, input bit eop,
                                input bit se, input bit br, input bit err);
        vec_t v;
        v.start = start; v.d = d; v.eop = eop; v.se = se; v.br = br; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Inputs already applied; sample outputs on the falling edge.
    task automatic check_cycle(input string name, input bit se, input bit br, input bit err);
        @(negedge clk);
        cmp({name, " shift_enable"}, ifc.shift_enable, se);
        cmp({name, " byte_received"}, ifc.byte_received, br);
        cmp({name, " stuff_error"}, ifc.stuff_error, err);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ifc.rcving = 1'b0;
        ifc.d_edge = 1'b0;
        for (int i = 0; i < n; i++) check_cycle("idle", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic free_run(input string name, input int ncyc);
        ifc.rcving = 1'b1;
        ifc.d_edge = 1'b0;
        ifc.d_orig = 1'b0;
        ifc.eop    = 1'b0;
        for (int c = 0; c < ncyc; c++) check_cycle(name, (c % 8) == 3, c == 60, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        ifc.rcving = 1'b1;
        ifc.d_edge = 1'b0;
        ifc.d_orig = 1'b0;
        ifc.eop    = 1'b0;
        #1;

        // Reset held with rcving high and edges toggling.
        for (int i = 0; i < 6; i++) begin
            ifc.d_edge = i[0];
            check_cycle("reset", 1'b0, 1'b0, 1'b0);
        end
        ifc.rcving = 1'b0;
        ifc.d_edge = 1'b0;
        n_rst = 1'b1;
        idle(2);

        // Free-running zeros: strobes at 3,11..59, byte at 60.
        free_run("freerun", 64);
        idle(2);

        // Zeros byte.
        for (int i = 0; i < 8; i++) add(i == 0, 1'b0, 1'b0, 1'b1, i == 7, 1'b0);
        // Unstuff: 1,1,1,1,1,1,0(stuffed),0,1.
        for (int i = 0; i < 6; i++) add(i == 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, !Unstuff, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, !Unstuff, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, Unstuff, 1'b0);
        // Stuff violation: seven 1s, then 0,0.
        for (int i = 0; i < 6; i++) add(i == 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, !Unstuff, 1'b0, Unstuff);
        add(1'b0, 1'b0, 1'b0, 1'b1, !Unstuff, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, Unstuff, 1'b0);
        // eop at a sample still shifts and clears the ones run.
        for (int i = 0; i < 5; i++) add(i == 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Abort after 5 bits, then a fresh 8-bit byte.
        for (int i = 0; i < 5; i++) add(i == 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) add(i == 0, 1'b0, 1'b0, 1'b1, i == 7, 1'b0);

        foreach (vecs[k]) begin
            if (vecs[k].start) idle(2);
            ifc.rcving = 1'b1;
            ifc.d_edge = 1'b0;
            ifc.d_orig = vecs[k].d;
            ifc.eop    = vecs[k].eop;
            for (int p = 0; p < 8; p++) begin
                check_cycle($sformatf("vec%0d", k),
                            (p == 3) && vecs[k].se,
                            (p == 4) && vecs[k].br,
                            (p == 4) && vecs[k].err);
            end
        end
        ifc.eop = 1'b0;
        idle(2);

        // Resync: edge at phase 6 (cycle 6), edge coincident with sample (cycle 17).
        ifc.rcving = 1'b1;
        ifc.d_orig = 1'b0;
        for (int c = 0; c < 28; c++) begin
            ifc.d_edge = (c == 6) || (c == 17);
            check_cycle("resync", (c == 3) || (c == 9) || (c == 17) || (c == 20), 1'b0, 1'b0);
        end
        ifc.d_edge = 1'b0;
        idle(2);

        // Async reset mid-byte while a strobe is active.
        ifc.rcving = 1'b1;
        for (int c = 0; c < 11; c++) check_cycle("prereset", (c % 8) == 3, 1'b0, 1'b0);
        @(negedge clk);
        cmp("presreset strobe", ifc.shift_enable, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        cmp("async shift_enable", ifc.shift_enable, 1'b0);
        cmp("async byte_received", ifc.byte_received, 1'b0);
        cmp("async stuff_error", ifc.stuff_error, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        free_run("postreset", 64);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
